// File: rtl/vga_fb_fetch.sv
// Framebuffer prefetcher: streams FB_WORDS pixel words from async SRAM into a small FIFO for the VGA side.
// Optional feature macro FB_DOUBLE_BUFFER_EN selects the second framebuffer at base FB_WORDS via buf_sel.
module vga_fb_fetch #(
    parameter int FB_WORDS   = 307200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        Clk,
    input  logic        Reset_h,
    input  logic        frame_start,
    input  logic        buf_sel,
    input  logic        pix_req,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        underflow,
    output logic        busy,
    output logic        frame_done,
    output logic [19:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ISS_W = $clog2(FB_WORDS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state_q, state_d;

    logic [19:0]      addr_q, addr_d, next_addr_q, next_addr_d;
    logic [ISS_W-1:0] iss_cnt_q, iss_cnt_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [15:0]      pix_data_q;
    logic             pix_valid_q, underflow_q;
    logic [19:0]      base_addr;
    logic             issue, push, pop, fifo_empty, room;

`ifdef FB_DOUBLE_BUFFER_EN
    assign base_addr = buf_sel ? 20'(FB_WORDS) : 20'd0;
`else
    logic unused_buf_sel;
    assign unused_buf_sel = buf_sel;
    assign base_addr      = 20'd0;
`endif

    // Entries plus the read still on the bus must fit, so a push can never find the FIFO full.
    assign fifo_empty = (count_q == '0);
    assign room       = (count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH);
    assign issue      = (state_q == FETCH) && !frame_start && room;
    assign push       = inflight_q && !frame_start;
    assign pop        = pix_req && !fifo_empty && !frame_start;

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        if (frame_start) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: if (issue && iss_cnt_q == ISS_W'(FB_WORDS - 1)) state_d = DRAIN;
                DRAIN: if (fifo_empty && !inflight_q) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        iss_cnt_d   = iss_cnt_q;
        inflight_d  = issue;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (frame_start) begin
            next_addr_d = base_addr;
            iss_cnt_d   = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end else begin
            if (issue) begin
                addr_d      = next_addr_q;
                next_addr_d = next_addr_q + 20'd1;
                iss_cnt_d   = iss_cnt_q + ISS_W'(1);
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            next_addr_q <= '0;
            iss_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            iss_cnt_q   <= iss_cnt_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (frame_start) begin
                pix_valid_q <= 1'b0;
                underflow_q <= 1'b0;
            end else if (pix_req) begin
                if (fifo_empty) begin
                    pix_valid_q <= 1'b0;
                    pix_data_q  <= '0;
                    underflow_q <= 1'b1;
                end else begin
                    pix_valid_q <= 1'b1;
                    pix_data_q  <= mem[rd_ptr_q];
                end
            end else begin
                pix_valid_q <= 1'b0;
            end
        end
    end

    // Write port kept free of reset so the storage maps onto RAM; reset still blocks the pending word.
    always_ff @(posedge Clk) begin
        if (push && !Reset_h) mem[wr_ptr_q] <= SRAM_DQ_in;
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign underflow = underflow_q;
    assign busy      = (state_q != IDLE);
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = (state_q == IDLE);
    assign SRAM_OE_N = (state_q == IDLE);
    assign SRAM_WE_N = 1'b1;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
endmodule

// File: tb/tb_vga_fb_fetch.sv
// Directed bench for vga_fb_fetch with a 32-word frame and a 4-entry FIFO; async SRAM model returns 0xA000+addr.
module tb_vga_fb_fetch;
    localparam int FB_WORDS   = 32;
    localparam int FIFO_DEPTH = 4;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic [19:0] EXP_BASE = 20'd32;
`else
    localparam logic [19:0] EXP_BASE = 20'd0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_h, frame_start, buf_sel, pix_req;
    logic [15:0] pix_data;
    logic        pix_valid, underflow, busy, frame_done;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    assign SRAM_DQ_in = 16'hA000 + SRAM_ADDR[15:0];

    vga_fb_fetch #(.FB_WORDS(FB_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .Clk(Clk), .Reset_h(Reset_h), .frame_start(frame_start), .buf_sel(buf_sel),
        .pix_req(pix_req), .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
        .busy(busy), .frame_done(frame_done), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_h = 1'b1; frame_start = 1'b0; buf_sel = 1'b0; pix_req = 1'b0;
        tick(); tick();
        vectors++; if (SRAM_ADDR !== 20'd0) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", SRAM_ADDR, 20'd0); end
        vectors++; if (SRAM_CE_N !== 1'b1) begin miscompares++; $display("FAIL reset_ce_n: got %b expected 1", SRAM_CE_N); end
        vectors++; if (SRAM_OE_N !== 1'b1) begin miscompares++; $display("FAIL reset_oe_n: got %b expected 1", SRAM_OE_N); end
        vectors++; if (SRAM_WE_N !== 1'b1) begin miscompares++; $display("FAIL reset_we_n: got %b expected 1", SRAM_WE_N); end
        vectors++; if ({SRAM_LB_N, SRAM_UB_N} !== 2'b00) begin miscompares++; $display("FAIL reset_lb_ub: got %b%b expected 00", SRAM_LB_N, SRAM_UB_N); end
        vectors++; if (pix_data !== 16'h0000) begin miscompares++; $display("FAIL reset_pix_data: got %h expected 0000", pix_data); end
        vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        Reset_h = 1'b0;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_fetch_stall();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fetch_busy: got %b expected 1", busy); end
        vectors++; if ({SRAM_CE_N, SRAM_OE_N} !== 2'b00) begin miscompares++; $display("FAIL fetch_ce_oe: got %b%b expected 00", SRAM_CE_N, SRAM_OE_N); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (SRAM_ADDR !== 20'(i)) begin miscompares++; $display("FAIL fetch_addr%0d: got %h expected %h", i, SRAM_ADDR, 20'(i)); end
            $display("fetch: read issued at addr %h", SRAM_ADDR);
        end
        repeat (4) tick();
        vectors++; if (SRAM_ADDR !== 20'd3) begin miscompares++; $display("FAIL stall_addr: got %h expected %h", SRAM_ADDR, 20'd3); end
        vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("FAIL stall_pix_valid: got %b expected 0", pix_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy: got %b expected 1", busy); end
    endtask

    task automatic test_stream();
        int          n     = 0;
        int          cyc   = 0;
        int          early = 0;
        logic [15:0] exp_pix;
        pix_req = 1'b1;
        while (n < 32 && cyc < 200) begin
            tick();
            cyc++;
            if (pix_valid) begin
                exp_pix = 16'hA000 + 16'(n);
                vectors++;
                if (pix_data !== exp_pix) begin miscompares++; $display("FAIL stream_pix%0d: got %h expected %h", n, pix_data, exp_pix); end
                $display("stream: pixel %0d data %h", n, pix_data);
                n++;
            end
            if (n < 32 && frame_done) early++;
        end
        pix_req = 1'b0;
        vectors++; if (n !== 32) begin miscompares++; $display("FAIL stream_count: got %0d expected 32", n); end
        vectors++; if (early !== 0) begin miscompares++; $display("FAIL stream_early_done: got %0d expected 0", early); end
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL stream_frame_done: got %b expected 1", frame_done); end
        tick();
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %b expected 0", frame_done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
        vectors++; if ({SRAM_CE_N, SRAM_OE_N} !== 2'b11) begin miscompares++; $display("FAIL idle_ce_oe: got %b%b expected 11", SRAM_CE_N, SRAM_OE_N); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL stream_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_underflow();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pix_req     = 1'b1;
        tick();
        pix_req = 1'b0;
        vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("FAIL uf_pix_valid: got %b expected 0", pix_valid); end
        vectors++; if (pix_data !== 16'h0000) begin miscompares++; $display("FAIL uf_pix_data: got %h expected 0000", pix_data); end
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_set: got %b expected 1", underflow); end
        repeat (3) tick();
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %b expected 1", underflow); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL uf_clear: got %b expected 0", underflow); end
        $display("underflow: sticky flag checked");
    endtask

    task automatic test_restart();
        int cyc = 0;
        pix_req = 1'b1;
        while (SRAM_ADDR !== 20'd17 && cyc < 200) begin tick(); cyc++; end
        vectors++; if (SRAM_ADDR !== 20'd17) begin miscompares++; $display("FAIL restart_reach17: got %h expected %h", SRAM_ADDR, 20'd17); end
        frame_start = 1'b1; pix_req = 1'b0;
        tick();
        frame_start = 1'b0;
        vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("FAIL restart_pix_valid: got %b expected 0", pix_valid); end
        tick();
        vectors++; if (SRAM_ADDR !== 20'd0) begin miscompares++; $display("FAIL restart_addr: got %h expected %h", SRAM_ADDR, 20'd0); end
        pix_req = 1'b1;
        cyc = 0;
        do begin tick(); cyc++; end while (!pix_valid && cyc < 20);
        vectors++; if (pix_valid !== 1'b1 || pix_data !== 16'hA000) begin miscompares++; $display("FAIL restart_first_pix: got %b/%h expected 1/a000", pix_valid, pix_data); end
        $display("restart: first pixel %h", pix_data);
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        pix_req = 1'b1;
        while (SRAM_ADDR !== 20'd10 && cyc < 200) begin tick(); cyc++; end
        vectors++; if (SRAM_ADDR !== 20'd10) begin miscompares++; $display("FAIL rmid_reach10: got %h expected %h", SRAM_ADDR, 20'd10); end
        Reset_h = 1'b1; pix_req = 1'b0;
        tick();
        vectors++; if (SRAM_ADDR !== 20'd0) begin miscompares++; $display("FAIL rmid_addr: got %h expected %h", SRAM_ADDR, 20'd0); end
        vectors++; if ({SRAM_CE_N, SRAM_OE_N} !== 2'b11) begin miscompares++; $display("FAIL rmid_ce_oe: got %b%b expected 11", SRAM_CE_N, SRAM_OE_N); end
        vectors++; if (pix_data !== 16'h0000 || pix_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_pix: got %b/%h expected 0/0000", pix_valid, pix_data); end
        vectors++; if ({underflow, busy, frame_done} !== 3'b000) begin miscompares++; $display("FAIL rmid_flags: got %b expected 000", {underflow, busy, frame_done}); end
        Reset_h = 1'b0; pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        vectors++; if (pix_valid !== 1'b0 || underflow !== 1'b1) begin miscompares++; $display("FAIL rmid_fifo_empty: got %b/%b expected 0/1", pix_valid, underflow); end
        repeat (2) tick();
        vectors++; if (SRAM_ADDR !== 20'd0 || SRAM_CE_N !== 1'b1) begin miscompares++; $display("FAIL rmid_no_idle_read: got %h/%b expected 00000/1", SRAM_ADDR, SRAM_CE_N); end
        $display("reset_mid: abort checked");
    endtask

    task automatic test_buf_sel();
        int          cyc = 0;
        logic [15:0] exp_pix;
        exp_pix = 16'hA000 + EXP_BASE[15:0];
        buf_sel = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; buf_sel = 1'b0;
        tick();
        vectors++; if (SRAM_ADDR !== EXP_BASE) begin miscompares++; $display("FAIL bufsel_addr: got %h expected %h", SRAM_ADDR, EXP_BASE); end
        pix_req = 1'b1;
        do begin tick(); cyc++; end while (!pix_valid && cyc < 20);
        pix_req = 1'b0;
        vectors++; if (pix_valid !== 1'b1 || pix_data !== exp_pix) begin miscompares++; $display("FAIL bufsel_first_pix: got %b/%h expected 1/%h", pix_valid, pix_data, exp_pix); end
        $display("buf_sel: first addr %h first pixel %h", EXP_BASE, pix_data);
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_stream();
        test_underflow();
        test_restart();
        test_reset_mid();
        test_buf_sel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
